// File: rtl/load_store_unit.sv
// Load/store unit: adapts core byte/half/word accesses onto a 32-bit ready-handshake bus.
// Optional bus timeout is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        bus_err_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state_q, state_d;
  logic   in_wait;
  logic   ready_hit;
  logic   timeout_hit;
  logic   load_done;

  function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd0, 3'd4: lane_be = 4'b0001 << off;
      3'd1, 3'd5: lane_be = 4'b0011 << {off[1], 1'b0};
      default:    lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate_store(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      3'd0, 3'd4: replicate_store = {4{wd[7:0]}};
      3'd1, 3'd5: replicate_store = {2{wd[15:0]}};
      default:    replicate_store = wd;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] size, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    byte_lane = word[{off, 3'b000} +: 8];
    half_lane = off[1] ? word[31:16] : word[15:0];
    case (size)
      3'd0:    extend_load = {{24{byte_lane[7]}}, byte_lane};
      3'd1:    extend_load = {{16{half_lane[15]}}, half_lane};
      3'd4:    extend_load = {24'd0, byte_lane};
      3'd5:    extend_load = {16'd0, half_lane};
      default: extend_load = word;
    endcase
  endfunction

  assign in_wait   = (state_q == S_WAIT);
  assign ready_hit = in_wait & core_req_i & mem_ready_i;
  assign load_done = ready_hit & ~core_we_i & ~rst_i;

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt_q;

  // Count holds the number of prior ready-less WAIT cycles, so the
  // TIMEOUT_CYCLES-th WAIT cycle is the one that sees TO_LAST.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else if (!in_wait && core_req_i) begin
      wait_cnt_q <= '0;
    end else if (in_wait && !mem_ready_i) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  assign timeout_hit = in_wait & core_req_i & ~mem_ready_i & (wait_cnt_q == TO_LAST);
`else
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_unused
  end
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (core_req_i) state_d = S_WAIT;
      S_WAIT:  if (!core_req_i || mem_ready_i || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus-side outputs are forced to zero while reset is held.
  always_comb begin
    mem_req_o    = core_req_i & ~rst_i;
    mem_we_o     = core_req_i & core_we_i & ~rst_i;
    core_stall_o = core_req_i & ~rst_i & ~ready_hit & ~timeout_hit;
    bus_err_o    = timeout_hit & ~rst_i;
    mem_be_o     = 4'd0;
    mem_addr_o   = 32'd0;
    mem_wd_o     = 32'd0;
    core_rd_o    = 32'd0;
    if (!rst_i) begin
      mem_be_o   = lane_be(core_size_i, core_addr_i[1:0]);
      mem_addr_o = core_addr_i;
      mem_wd_o   = replicate_store(core_size_i, core_wd_i);
    end
    if (load_done) begin
      core_rd_o = extend_load(core_size_i, core_addr_i[1:0], mem_rd_i);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboard of expected load data
// plus per-cycle checks of handshake, byte enables and store data.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_ready;
  logic        bus_err;

  int tests;
  int fails;
  logic [31:0] exp_q[$];

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd), .core_rd_o(core_rd),
    .core_stall_o(core_stall), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [7:0]  lanes [4];
    logic [7:0]  b;
    logic [15:0] h;
    lanes[0] = w[7:0];  lanes[1] = w[15:8];
    lanes[2] = w[23:16]; lanes[3] = w[31:24];
    b = lanes[a[1:0]];
    h = a[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
    case (size)
      3'd0:    return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      3'd1:    return h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0, 3'd4: case (a)
                    2'd0: return 4'b0001;
                    2'd1: return 4'b0010;
                    2'd2: return 4'b0100;
                    default: return 4'b1000;
                  endcase
      3'd1, 3'd5: return a[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one access; ready asserted in WAIT cycle number `delay` (0-based).
  task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdw, input int delay,
                           input logic early_ready, input logic [31:0] exp_rd,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd, input string name);
    logic done;
    logic [31:0] e;
    done = 1'b0;
    start_cycle();
    core_req = 1'b1; core_we = we; core_size = size; core_addr = addr;
    core_wd = wd; mem_rd = rdw;
    exp_q.push_back(exp_rd);
    for (int k = 0; k < delay + 10; k++) begin
      if (k > 0) start_cycle();
      mem_ready = (k == delay + 1) || (early_ready && k == 0);
      @(negedge clk);
      tests++;
      if (mem_req !== 1'b1) begin fails++; $display("FAIL %s mem_req: got %b want 1 (cycle %0d)", name, mem_req, k); end
      tests++;
      if (mem_be !== exp_be) begin fails++; $display("FAIL %s mem_be: got %b want %b", name, mem_be, exp_be); end
      tests++;
      if (mem_we !== we) begin fails++; $display("FAIL %s mem_we: got %b want %b", name, mem_we, we); end
      tests++;
      if (mem_addr !== addr) begin fails++; $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, addr); end
      tests++;
      if (bus_err !== 1'b0) begin fails++; $display("FAIL %s bus_err: got %b want 0", name, bus_err); end
      if (we) begin
        tests++;
        if (mem_wd !== exp_wd) begin fails++; $display("FAIL %s mem_wd: got %h want %h", name, mem_wd, exp_wd); end
      end
      if (core_stall === 1'b0) begin
        tests++;
        if (k != delay + 1) begin fails++; $display("FAIL %s stall_cycles: got %0d want %0d", name, k, delay + 1); end
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL %s scoreboard: got completion want none pending", name);
        end else begin
          e = exp_q.pop_front();
          if (core_rd !== e) begin fails++; $display("FAIL %s core_rd: got %h want %h", name, core_rd, e); end
        end
        done = 1'b1;
        break;
      end else begin
        tests++;
        if (core_rd !== 32'd0) begin fails++; $display("FAIL %s core_rd_stall: got %h want 0", name, core_rd); end
      end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s completion: got none within %0d cycles want completion", name, delay + 10);
      exp_q.delete();
    end
  endtask

  task automatic go_idle();
    start_cycle();
    core_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (core_stall !== 1'b0 || mem_req !== 1'b0) begin
      fails++; $display("FAIL idle: got stall=%b req=%b want 0 0", core_stall, mem_req);
    end
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wd, core_rd, core_stall, bus_err} !== '0) begin
      fails++;
      $display("FAIL %s outputs: got req=%b we=%b be=%b addr=%h wd=%h rd=%h stall=%b err=%b want all 0",
               name, mem_req, mem_we, mem_be, mem_addr, mem_wd, core_rd, core_stall, bus_err);
    end
  endtask

  task automatic test_reset();
    core_req = 1'b1; core_we = 1'b1; core_size = 3'd2; core_addr = 32'h1234_5678;
    core_wd = 32'hCAFE_F00D; mem_rd = 32'h5555_AAAA; mem_ready = 1'b1; rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_all_zero("reset_hold");
    end
    start_cycle();
    rst = 1'b0; core_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (core_stall !== 1'b0 || mem_req !== 1'b0) begin
      fails++; $display("FAIL reset_release: got stall=%b req=%b want 0 0", core_stall, mem_req);
    end
  endtask

  task automatic test_loads();
    do_access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 4'b1111, 32'h0, "LW");
    go_idle();
    do_access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80123456, 0, 1'b0, 32'hFFFFFF80, 4'b1000, 32'h0, "LB");
    go_idle();
    do_access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80123456, 0, 1'b0, 32'h00000080, 4'b1000, 32'h0, "LBU");
    go_idle();
    do_access(1'b0, 3'd1, 32'h102, 32'h0, 32'h80123456, 0, 1'b0, 32'hFFFF8012, 4'b1100, 32'h0, "LH");
    go_idle();
    do_access(1'b0, 3'd5, 32'h100, 32'h0, 32'h8012F456, 1, 1'b0, 32'h0000F456, 4'b0011, 32'h0, "LHU");
    go_idle();
  endtask

  task automatic test_stores();
    do_access(1'b1, 3'd0, 32'h201, 32'h000000A5, 32'hFFFFFFFF, 0, 1'b0, 32'h0, 4'b0010, 32'hA5A5A5A5, "SB");
    go_idle();
    do_access(1'b1, 3'd1, 32'h202, 32'h00001234, 32'hFFFFFFFF, 0, 1'b0, 32'h0, 4'b1100, 32'h12341234, "SH");
    go_idle();
    do_access(1'b1, 3'd2, 32'h204, 32'h89ABCDEF, 32'h0, 2, 1'b0, 32'h0, 4'b1111, 32'h89ABCDEF, "SW");
    go_idle();
  endtask

  task automatic test_delay_and_back_to_back();
    do_access(1'b0, 3'd2, 32'h400, 32'h0, 32'h0BADF00D, 5, 1'b0, 32'h0BADF00D, 4'b1111, 32'h0, "LW_delay5");
    do_access(1'b1, 3'd2, 32'h404, 32'h13579BDF, 32'h0, 0, 1'b0, 32'h0, 4'b1111, 32'h13579BDF, "SW_b2b");
    do_access(1'b0, 3'd0, 32'h405, 32'h0, 32'h0000FE00, 0, 1'b0, 32'hFFFFFFFE, 4'b0010, 32'h0, "LB_b2b");
    go_idle();
    do_access(1'b0, 3'd2, 32'h408, 32'h0, 32'h24682468, 1, 1'b1, 32'h24682468, 4'b1111, 32'h0, "LW_early_ready");
    go_idle();
  endtask

  task automatic test_random_loads();
    logic [2:0]  sz;
    logic [31:0] a, w;
    for (int i = 0; i < 16; i++) begin
      sz = 3'($urandom_range(0, 7));
      a  = $urandom;
      w  = $urandom;
      do_access(1'b0, sz, a, 32'h0, w, int'($urandom_range(0, 3)), 1'b0, model_load(sz, a, w),
                model_be(sz, a[1:0]), 32'h0, "rand_load");
    end
    go_idle();
  endtask

  task automatic test_reset_mid_wait();
    start_cycle();
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h300;
    mem_rd = 32'h11112222; mem_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (core_stall !== 1'b1) begin fails++; $display("FAIL rst_wait_idle: got stall=%b want 1", core_stall); end
    start_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_in_wait");
    start_cycle();
    rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (core_stall !== 1'b1 || core_rd !== 32'd0) begin
      fails++; $display("FAIL rst_late_ready: got stall=%b rd=%h want 1 0", core_stall, core_rd);
    end
    go_idle();
    do_access(1'b0, 3'd2, 32'h304, 32'h0, 32'h33334444, 0, 1'b0, 32'h33334444, 4'b1111, 32'h0, "after_reset");
    go_idle();
  endtask

  task automatic test_abort();
    start_cycle();
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h500;
    mem_rd = 32'h77778888; mem_ready = 1'b0;
    @(negedge clk);
    start_cycle();
    core_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b0 || core_stall !== 1'b0 || core_rd !== 32'd0) begin
      fails++; $display("FAIL abort: got req=%b stall=%b rd=%h want 0 0 0", mem_req, core_stall, core_rd);
    end
    do_access(1'b0, 3'd2, 32'h504, 32'h0, 32'h9999AAAA, 0, 1'b0, 32'h9999AAAA, 4'b1111, 32'h0, "after_abort");
    go_idle();
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    start_cycle();
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h600;
    mem_rd = 32'hFFFFFFFF; mem_ready = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) start_cycle();
      @(negedge clk);
      tests++;
      if (k < 4) begin
        if (core_stall !== 1'b1 || bus_err !== 1'b0) begin
          fails++; $display("FAIL timeout_pre: got stall=%b err=%b want 1 0 (cycle %0d)", core_stall, bus_err, k);
        end
      end else begin
        if (core_stall !== 1'b0 || bus_err !== 1'b1 || core_rd !== 32'd0) begin
          fails++; $display("FAIL timeout_hit: got stall=%b err=%b rd=%h want 0 1 0", core_stall, bus_err, core_rd);
        end
      end
    end
    go_idle();
    tests++;
    if (bus_err !== 1'b0) begin fails++; $display("FAIL timeout_pulse: got err=%b want 0", bus_err); end
    do_access(1'b0, 3'd2, 32'h604, 32'h0, 32'h4444CCCC, 3, 1'b0, 32'h4444CCCC, 4'b1111, 32'h0, "ready_at_timeout");
    go_idle();
  endtask
`else
  task automatic test_hold();
    start_cycle();
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h600;
    mem_rd = 32'hFFFFFFFF; mem_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) start_cycle();
      @(negedge clk);
      tests++;
      if (core_stall !== 1'b1 || bus_err !== 1'b0) begin
        fails++; $display("FAIL hold: got stall=%b err=%b want 1 0 (cycle %0d)", core_stall, bus_err, k);
      end
    end
    go_idle();
  endtask
`endif

  initial begin
    tests = 0; fails = 0;
    clk = 1'b0; rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_size = 3'd0;
    core_addr = 32'd0; core_wd = 32'd0; mem_rd = 32'd0; mem_ready = 1'b0;
    test_reset();
    test_loads();
    test_stores();
    test_delay_and_back_to_back();
    test_random_loads();
    test_reset_mid_wait();
    test_abort();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
